// File: rtl/axi_perf_ctrl_pkg.sv
// Shared types and constants for the performance-monitor run controller:
// FSM state encoding, status-word bit positions and the counter helper.
package axi_perf_ctrl_pkg;

  typedef logic [31:0] t_ACX_USER_REG;

  localparam int DEFAULT_NUM_RESULTS = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUN     = 3'd3,
    ST_STOP    = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_CAPTURE = 3'd6
  } state_t;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_MSB = 2;
  localparam int STATUS_BUSY_BIT  = 3;
  localparam int STATUS_ABORT_BIT = 4;
  localparam int STATUS_SEQ_LSB   = 16;
  localparam int STATUS_SEQ_MSB   = 31;

  // Run counter sticks at all-ones instead of wrapping on very long runs.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/perf_snapshot_bank.sv
// Holding register bank for the captured monitor result words; loads all
// words together on a single strobe and holds them otherwise.
module perf_snapshot_bank
  import axi_perf_ctrl_pkg::*;
#(
  parameter int NUM_RESULTS = DEFAULT_NUM_RESULTS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  t_ACX_USER_REG [NUM_RESULTS-1:0]  data_in,
  output t_ACX_USER_REG [NUM_RESULTS-1:0]  data_out
);

  // Snapshot words: cleared by reset, replaced as a set on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end else begin
      data_out <= data_out;
    end
  end

endmodule

// File: rtl/axi_perf_run_ctrl.sv
// Sequences one measurement run of the AXI performance monitor
// (clear, arm, run, stop, settle, capture) and publishes the captured results.
module axi_perf_run_ctrl
  import axi_perf_ctrl_pkg::*;
#(
  parameter int NUM_RESULTS   = DEFAULT_NUM_RESULTS,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_cmd_start,
  input  logic                             i_cmd_stop,
  input  logic                             i_cmd_abort,
  input  logic [31:0]                      i_run_cycles,
  input  t_ACX_USER_REG [NUM_RESULTS-1:0]  i_results,
  output logic                             o_mon_start,
  output logic                             o_mon_stop,
  output logic                             o_mon_counter_reset,
  output t_ACX_USER_REG [NUM_RESULTS-1:0]  o_snapshot,
  output logic [31:0]                      o_elapsed,
  output t_ACX_USER_REG                    o_status,
  output logic                             o_done
);

  localparam logic [3:0] CLEAR_LOAD  = 4'(CLEAR_CYCLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  timer;
  logic [31:0] cnt;
  logic [31:0] run_len;
  logic [15:0] seq;
  logic        aborted;
  logic        busy;
  logic [31:0] cnt_inc;
  logic        length_hit;
  logic        snap_load;

  assign cnt_inc    = sat_inc32(cnt);
  assign length_hit = (run_len != 32'd0) && (cnt_inc == run_len);
  assign snap_load  = (state == ST_CAPTURE);

  // Run sequencer: state, run counter, capture bookkeeping and monitor strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state               <= ST_IDLE;
      timer               <= 4'd0;
      cnt                 <= 32'd0;
      run_len             <= 32'd0;
      seq                 <= 16'd0;
      aborted             <= 1'b0;
      busy                <= 1'b0;
      o_mon_start         <= 1'b0;
      o_mon_stop          <= 1'b0;
      o_mon_counter_reset <= 1'b0;
      o_elapsed           <= 32'd0;
      o_done              <= 1'b0;
    end else begin
      o_mon_start         <= 1'b0;
      o_mon_stop          <= 1'b0;
      o_mon_counter_reset <= 1'b0;
      o_done              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_cmd_start) begin
            state               <= ST_CLEAR;
            run_len             <= i_run_cycles;
            cnt                 <= 32'd0;
            timer               <= CLEAR_LOAD;
            aborted             <= 1'b0;
            busy                <= 1'b1;
            o_mon_counter_reset <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (i_cmd_abort) begin
            state      <= ST_STOP;
            aborted    <= 1'b1;
            o_mon_stop <= 1'b1;
          end else if (timer == 4'd0) begin
            state       <= ST_ARM;
            o_mon_start <= 1'b1;
          end else begin
            timer               <= timer - 4'd1;
            o_mon_counter_reset <= 1'b1;
          end
        end
        ST_ARM: begin
          if (i_cmd_abort) begin
            state      <= ST_STOP;
            aborted    <= 1'b1;
            o_mon_stop <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The exiting cycle is still a counted RUN cycle.
          cnt <= cnt_inc;
          if (i_cmd_abort) begin
            state      <= ST_STOP;
            aborted    <= 1'b1;
            o_mon_stop <= 1'b1;
          end else if (i_cmd_stop || length_hit) begin
            state      <= ST_STOP;
            o_mon_stop <= 1'b1;
          end
        end
        ST_STOP: begin
          if (SETTLE_CYCLES == 0) begin
            state <= ST_CAPTURE;
          end else begin
            state <= ST_SETTLE;
            timer <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (timer == 4'd0) begin
            state <= ST_CAPTURE;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        ST_CAPTURE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          o_elapsed <= cnt;
          seq       <= seq + 16'd1;
          o_done    <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Status word assembled directly from flops; unused bits stay zero.
  always_comb begin
    o_status = '0;
    o_status[STATUS_STATE_MSB:STATUS_STATE_LSB] = state;
    o_status[STATUS_BUSY_BIT]                   = busy;
    o_status[STATUS_ABORT_BIT]                  = aborted;
    o_status[STATUS_SEQ_MSB:STATUS_SEQ_LSB]     = seq;
  end

  perf_snapshot_bank #(
    .NUM_RESULTS (NUM_RESULTS)
  ) u_snapshot_bank (
    .clk      (i_clk),
    .reset    (i_reset),
    .load     (snap_load),
    .data_in  (i_results),
    .data_out (o_snapshot)
  );

endmodule

// File: tb/tb_axi_perf_run_ctrl.sv
// Scoreboard bench for axi_perf_run_ctrl with default parameters: expected
// captures are queued when a run is launched and compared when o_done fires.
module tb_axi_perf_run_ctrl;
  import axi_perf_ctrl_pkg::*;

  localparam int NR = 6;

  typedef struct packed {
    logic [31:0]      elapsed;
    logic [15:0]      seq;
    logic             aborted;
    logic [31:0]      done_cyc;
    logic [NR*32-1:0] snap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic abort = 1'b0;
  logic [31:0] run_cycles = 32'd0;
  t_ACX_USER_REG [NR-1:0] results = '0;
  logic mon_start, mon_stop, mon_cr, done;
  t_ACX_USER_REG [NR-1:0] snapshot;
  logic [31:0] elapsed;
  t_ACX_USER_REG status;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb_q[$];

  int cr_cnt = 0, st_cnt = 0, sp_cnt = 0, dn_cnt = 0;
  int cr_first = -1, st_cyc = -1, sp_cyc = -1;
  logic cr_prev = 1'b0;

  axi_perf_run_ctrl #(.NUM_RESULTS(NR), .CLEAR_CYCLES(2), .SETTLE_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_start(start), .i_cmd_stop(stop),
    .i_cmd_abort(abort), .i_run_cycles(run_cycles), .i_results(results),
    .o_mon_start(mon_start), .o_mon_stop(mon_stop), .o_mon_counter_reset(mon_cr),
    .o_snapshot(snapshot), .o_elapsed(elapsed), .o_status(status), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log of monitor strobes, stamped with the cycle they are visible in.
  always @(negedge clk) begin
    if (mon_cr === 1'b1) begin
      cr_cnt <= cr_cnt + 1;
      if (!cr_prev) cr_first <= cyc;
    end
    cr_prev <= (mon_cr === 1'b1);
    if (mon_start === 1'b1) begin st_cnt <= st_cnt + 1; st_cyc <= cyc; end
    if (mon_stop === 1'b1) begin sp_cnt <= sp_cnt + 1; sp_cyc <= cyc; end
    if (done === 1'b1) dn_cnt <= dn_cnt + 1;
  end

  function automatic t_ACX_USER_REG res_val(int c, int k);
    return (32'(c) * 32'd65539) ^ (32'(k) << 28) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [NR*32-1:0] snap_at(int c);
    logic [NR*32-1:0] v;
    for (int k = 0; k < NR; k++) v[k*32 +: 32] = res_val(c, k);
    return v;
  endfunction

  // Live result words change every cycle so the capture cycle is observable.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) results[k] = res_val(cyc, k);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

  task automatic begin_run(input logic [31:0] len, output int c0);
    @(negedge clk);
    start = 1'b1;
    run_cycles = len;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mon_start !== 1'b0) begin failures++; $display("FAIL reset_mon_start got=%b exp=0", mon_start); end
    checks++; if (mon_stop !== 1'b0) begin failures++; $display("FAIL reset_mon_stop got=%b exp=0", mon_stop); end
    checks++; if (mon_cr !== 1'b0) begin failures++; $display("FAIL reset_counter_reset got=%b exp=0", mon_cr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (snapshot !== '0) begin failures++; $display("FAIL reset_snapshot got=%h exp=0", snapshot); end
    checks++; if (elapsed !== 32'd0) begin failures++; $display("FAIL reset_elapsed got=%h exp=0", elapsed); end
    checks++; if (status !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", status); end
    rst = 1'b0;
    stop = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (status !== 32'd0 || sp_cnt != 0) begin failures++; $display("FAIL idle_ignores_stop_abort status=%h stops=%0d exp=0/0", status, sp_cnt); end
  endtask

  task automatic test_fixed_run();
    int c0, b_cr, b_st, b_sp;
    bit ok;
    exp_t e;
    b_cr = cr_cnt; b_st = st_cnt; b_sp = sp_cnt;
    begin_run(32'd100, c0);
    e.elapsed = 32'd100; e.seq = 16'd1; e.aborted = 1'b0; e.done_cyc = 32'(c0 + 110); e.snap = snap_at(c0 + 109);
    sb_q.push_back(e);
    at_cycle(c0 + 50);
    checks++; if (status[3:0] !== 4'b1011) begin failures++; $display("FAIL fixed_midrun_state got=%h exp=b", status[3:0]); end
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fixed_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL fixed_done_cycle got=%0d exp=%0d", cyc - c0, e.done_cyc - 32'(c0)); end
    checks++; if (cr_first != c0 + 1 || cr_cnt - b_cr != 2) begin failures++; $display("FAIL fixed_counter_reset first=%0d count=%0d exp=1/2", cr_first - c0, cr_cnt - b_cr); end
    checks++; if (st_cyc != c0 + 3 || st_cnt - b_st != 1) begin failures++; $display("FAIL fixed_mon_start cyc=%0d count=%0d exp=3/1", st_cyc - c0, st_cnt - b_st); end
    checks++; if (sp_cyc != c0 + 104 || sp_cnt - b_sp != 1) begin failures++; $display("FAIL fixed_mon_stop cyc=%0d count=%0d exp=104/1", sp_cyc - c0, sp_cnt - b_sp); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL fixed_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL fixed_status got=%h exp seq=%h ab=%b", status, e.seq, e.aborted); end
    checks++; if (snapshot !== e.snap) begin failures++; $display("FAIL fixed_snapshot got=%h exp=%h", snapshot, e.snap); end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b0 || snapshot !== e.snap) begin failures++; $display("FAIL fixed_hold done=%b snap_ok=%b exp=0/1", done, snapshot === e.snap); end
  endtask

  task automatic test_stop_run();
    int c0, b_st, b_sp;
    bit ok;
    exp_t e;
    b_st = st_cnt; b_sp = sp_cnt;
    begin_run(32'd0, c0);
    e.elapsed = 32'd47; e.seq = 16'd2; e.aborted = 1'b0; e.done_cyc = 32'(c0 + 57); e.snap = snap_at(c0 + 56);
    sb_q.push_back(e);
    at_cycle(c0 + 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    at_cycle(c0 + 50);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stop_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL stop_done_cycle got=%0d exp=57", cyc - c0); end
    checks++; if (st_cnt - b_st != 1 || sp_cyc != c0 + 51 || sp_cnt - b_sp != 1) begin failures++; $display("FAIL stop_strobes starts=%0d stop_cyc=%0d stops=%0d exp=1/51/1", st_cnt - b_st, sp_cyc - c0, sp_cnt - b_sp); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL stop_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL stop_status got=%h exp seq=%h ab=%b", status, e.seq, e.aborted); end
    checks++; if (snapshot !== e.snap) begin failures++; $display("FAIL stop_snapshot got=%h exp=%h", snapshot, e.snap); end
  endtask

  task automatic test_abort_clear();
    int c0, b_st, b_sp;
    bit ok;
    exp_t e;
    b_st = st_cnt; b_sp = sp_cnt;
    begin_run(32'd100, c0);
    e.elapsed = 32'd0; e.seq = 16'd3; e.aborted = 1'b1; e.done_cyc = 32'(c0 + 9); e.snap = snap_at(c0 + 8);
    sb_q.push_back(e);
    at_cycle(c0 + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL abort_done_cycle got=%0d exp=9", cyc - c0); end
    checks++; if (st_cnt != b_st || sp_cyc != c0 + 3 || sp_cnt - b_sp != 1) begin failures++; $display("FAIL abort_strobes starts=%0d stop_cyc=%0d stops=%0d exp=0/3/1", st_cnt - b_st, sp_cyc - c0, sp_cnt - b_sp); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL abort_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL abort_status got=%h exp seq=%h ab=%b", status, e.seq, e.aborted); end
    checks++; if (snapshot !== e.snap) begin failures++; $display("FAIL abort_snapshot got=%h exp=%h", snapshot, e.snap); end
  endtask

  task automatic test_back_to_back();
    int c0, c1, b_st, b_sp;
    bit ok;
    exp_t e;
    b_st = st_cnt; b_sp = sp_cnt;
    begin_run(32'd0, c0);
    e.elapsed = 32'd27; e.seq = 16'd4; e.aborted = 1'b1; e.done_cyc = 32'(c0 + 37); e.snap = snap_at(c0 + 36);
    sb_q.push_back(e);
    at_cycle(c0 + 20);
    start = 1'b1; run_cycles = 32'd5;
    @(negedge clk);
    start = 1'b0;
    at_cycle(c0 + 30);
    stop = 1'b1; abort = 1'b1;
    @(negedge clk);
    stop = 1'b0; abort = 1'b0;
    wait_done(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=37", cyc - c0); end
    checks++; if (st_cnt - b_st != 1 || sp_cyc != c0 + 31 || sp_cnt - b_sp != 1) begin failures++; $display("FAIL b2b_strobes starts=%0d stop_cyc=%0d stops=%0d exp=1/31/1", st_cnt - b_st, sp_cyc - c0, sp_cnt - b_sp); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL b2b_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL b2b_status got=%h exp seq=%h ab=%b", status, e.seq, e.aborted); end
    b_sp = sp_cnt;
    begin_run(32'd10, c1);
    e.elapsed = 32'd10; e.seq = 16'd5; e.aborted = 1'b0; e.done_cyc = 32'(c1 + 20); e.snap = snap_at(c1 + 19);
    sb_q.push_back(e);
    at_cycle(c1 + 13);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    at_cycle(c1 + 16);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL len_stop_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL len_stop_done_cycle got=%0d exp=20", cyc - c1); end
    checks++; if (sp_cyc != c1 + 14 || sp_cnt - b_sp != 1) begin failures++; $display("FAIL len_stop_strobes stop_cyc=%0d stops=%0d exp=14/1", sp_cyc - c1, sp_cnt - b_sp); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL len_stop_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL len_stop_status got=%h exp seq=%h ab=%b", status, e.seq, e.aborted); end
    checks++; if (snapshot !== e.snap) begin failures++; $display("FAIL len_stop_snapshot got=%h exp=%h", snapshot, e.snap); end
  endtask

  task automatic test_reset_midrun();
    int c0, c1, b_sp, b_dn;
    bit ok;
    exp_t e;
    b_sp = sp_cnt; b_dn = dn_cnt;
    begin_run(32'd0, c0);
    at_cycle(c0 + 60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({mon_start, mon_stop, mon_cr, done} !== 4'b0000) begin failures++; $display("FAIL midreset_strobes got=%b exp=0000", {mon_start, mon_stop, mon_cr, done}); end
    checks++; if (snapshot !== '0 || elapsed !== 32'd0) begin failures++; $display("FAIL midreset_data snap=%h elapsed=%h exp=0", snapshot, elapsed); end
    checks++; if (status !== 32'd0) begin failures++; $display("FAIL midreset_status got=%h exp=0", status); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (sp_cnt != b_sp || dn_cnt != b_dn) begin failures++; $display("FAIL midreset_no_pulses stops=%0d dones=%0d exp=0/0", sp_cnt - b_sp, dn_cnt - b_dn); end
    begin_run(32'd5, c1);
    e.elapsed = 32'd5; e.seq = 16'd1; e.aborted = 1'b0; e.done_cyc = 32'(c1 + 15); e.snap = snap_at(c1 + 14);
    sb_q.push_back(e);
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL postreset_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL postreset_done_cycle got=%0d exp=15", cyc - c1); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL postreset_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL postreset_status got=%h exp seq=%h ab=%b", status, e.seq, e.aborted); end
  endtask

  task automatic test_seq_wrap();
    int c0;
    bit ok;
    exp_t e;
    // Stands in for 65535 completed one-cycle runs.
    @(negedge clk);
    dut.seq <= 16'hFFFF;
    begin_run(32'd1, c0);
    e.elapsed = 32'd1; e.seq = 16'h0000; e.aborted = 1'b0; e.done_cyc = 32'(c0 + 11); e.snap = snap_at(c0 + 10);
    sb_q.push_back(e);
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_done_timeout got=none exp=done"); end
    e = sb_q.pop_front();
    checks++; if (32'(cyc) !== e.done_cyc) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=11", cyc - c0); end
    checks++; if (elapsed !== e.elapsed) begin failures++; $display("FAIL wrap_elapsed got=%0d exp=%0d", elapsed, e.elapsed); end
    checks++; if (status !== {e.seq, 11'd0, e.aborted, 1'b0, 3'd0}) begin failures++; $display("FAIL wrap_status got=%h exp seq=%h", status, e.seq); end
    checks++; if (snapshot !== e.snap) begin failures++; $display("FAIL wrap_snapshot got=%h exp=%h", snapshot, e.snap); end
  endtask

  initial begin
    test_reset();
    test_fixed_run();
    test_stop_run();
    test_abort_clear();
    test_back_to_back();
    test_reset_midrun();
    test_seq_wrap();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
